pwm_peripheral: RTL

Sixteen-channel output stage sitting directly downstream of the SPI register block: it consumes the five 8-bit control registers (output enables, PWM enables, duty cycle) and drives the 16 chip output pins. Each pin is either forced low, forced high, or driven by a shared 8-bit PWM waveform. Duty-cycle changes are applied only at PWM period boundaries, so every period is glitch-free.

---
 rtl/pwm_peripheral_if.sv | 23 ++
 rtl/pwm_peripheral.sv | 60 ++++++
 2 files changed

// File: rtl/pwm_peripheral_if.sv
// Control-register and pin-drive bundle between the SPI register block and the
// PWM output stage.
interface pwm_peripheral_if;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    output pwm_duty_cycle,
    input  out, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    input  pwm_duty_cycle,
    output out, period_start
  );
endinterface

// File: rtl/pwm_peripheral.sv
// Sixteen-pin output stage: each pin forced low, forced high, or driven by one
// shared 8-bit PWM whose duty is shadowed and only updated at period boundaries.
module pwm_peripheral #(
  parameter int CLK_DIV = 13
) (
  input  logic           clk,
  input  logic           rst_n,
  pwm_peripheral_if.slave bus
);

  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

  logic [7:0]  clk_cnt_q, clk_cnt_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [7:0]  duty_shadow_q, duty_shadow_d;
  logic [15:0] out_q, out_d;
  logic        period_start_q, period_start_d;

  logic        tick;
  logic        wrap;
  logic        pwm_sig;
  logic [15:0] en_out;
  logic [15:0] en_pwm;

  always_comb begin
    tick           = (clk_cnt_q == DIV_MAX);
    wrap           = tick && (pwm_cnt_q == 8'hFF);
    clk_cnt_d      = tick ? 8'd0 : clk_cnt_q + 8'd1;
    pwm_cnt_d      = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    // The shadow only moves on the last step of a period, so a period never
    // sees two different duty values.
    duty_shadow_d  = wrap ? bus.pwm_duty_cycle : duty_shadow_q;
    // 0xFF means fully on rather than 255/256.
    pwm_sig        = (duty_shadow_q == 8'hFF) || (pwm_cnt_q < duty_shadow_q);
    en_out         = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    en_pwm         = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
    out_d          = en_out & (~en_pwm | {16{pwm_sig}});
    period_start_d = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt_q      <= 8'd0;
      pwm_cnt_q      <= 8'd0;
      duty_shadow_q  <= 8'd0;
      out_q          <= 16'h0000;
      period_start_q <= 1'b0;
    end else begin
      clk_cnt_q      <= clk_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      duty_shadow_q  <= duty_shadow_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign bus.out          = out_q;
  assign bus.period_start = period_start_q;

endmodule
